// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the fractional baud
// accumulator increment used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Rounded increment so that acc[accWidth] toggles at baud*os on average.
    // 64-bit arithmetic: baud*os shifted left overflows 32 bits at common rates.
    function automatic longint calcInc(input longint clkFreq, input longint baud,
                                       input longint os, input int accWidth);
        return (((baud * os) << (accWidth - 4)) + (clkFreq >> 5)) / (clkFreq >> 4);
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Fractional-N tick generator: one-clk tick at Baud*Oversampling on average,
// derived from the carry of a free-running accumulator.
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 40000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 1,
    parameter int AccWidth     = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [AccWidth:0] Inc =
        (AccWidth+1)'(calcInc(longint'(ClkFrequency), longint'(Baud),
                              longint'(Oversampling), AccWidth));

    logic [AccWidth:0] acc;

    // The carry bit is dropped every clk, so it is high for exactly one clk per overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[AccWidth-1:0]} + Inc;
        end
    end

    assign tick = acc[AccWidth];

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 oversampling UART receiver with start-bit qualification, framing error,
// line-idle and end-of-packet reporting for the command decoder.
`ifndef UART_CLK
`define UART_CLK 40000000
`endif
`ifndef UART_BAUD
`define UART_BAUD 115200
`endif

module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int ClkFrequency = `UART_CLK,
    parameter int Baud         = `UART_BAUD,
    parameter int Oversampling = 16,
    parameter int AccWidth     = 16,
    parameter int GapBits      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_idle,
    output logic       RxD_endofpacket,
    output logic       RxD_busy,
    output logic [2:0] dbgState
);

    localparam int SW = $clog2(Oversampling);
    localparam int GapMaxInt = GapBits * Oversampling;
    localparam int GW = $clog2(GapMaxInt + 1);
    localparam logic [SW-1:0] HalfLast = SW'(Oversampling / 2 - 1);
    localparam logic [SW-1:0] FullLast = SW'(Oversampling - 1);
    localparam logic [GW-1:0] GapMax   = GW'(GapMaxInt);
    localparam logic [GW-1:0] GapLast  = GW'(GapMaxInt - 1);

    logic          tick;
    logic [1:0]    rxSync;
    logic [2:0]    rxTaps;
    logic          rxFilt;
    logic [2:0]    state;
    logic [SW-1:0] sampleCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic [GW-1:0] gapCnt;
    logic          byteSeen;

    uart_baud_tick_gen #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud),
        .Oversampling(Oversampling),
        .AccWidth    (AccWidth)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Synchronizer and majority filter start at 1 so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxSync <= 2'b11;
            rxTaps <= 3'b111;
        end else begin
            rxSync <= {rxSync[0], RxD};
            if (tick) begin
                rxTaps <= {rxTaps[1:0], rxSync[1]};
            end
        end
    end

    assign rxFilt = (rxTaps[0] & rxTaps[1]) | (rxTaps[0] & rxTaps[2]) | (rxTaps[1] & rxTaps[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sampleCnt      <= '0;
            bitCnt         <= '0;
            shiftReg       <= '0;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
        end else begin
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rxFilt) begin
                            state     <= ST_START;
                            sampleCnt <= '0;
                        end
                    end
                    // Half a bit in: a start bit that has gone high again was a glitch.
                    ST_START: begin
                        if (sampleCnt == HalfLast) begin
                            sampleCnt <= '0;
                            bitCnt    <= '0;
                            state     <= rxFilt ? ST_IDLE : ST_DATA;
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (sampleCnt == FullLast) begin
                            sampleCnt <= '0;
                            shiftReg  <= {rxFilt, shiftReg[7:1]};
                            bitCnt    <= bitCnt + 1'b1;
                            if (bitCnt == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (sampleCnt == FullLast) begin
                            sampleCnt <= '0;
                            if (rxFilt) begin
                                RxD_data       <= shiftReg;
                                RxD_data_ready <= 1'b1;
                                state          <= ST_IDLE;
                            end else begin
                                RxD_frame_err <= 1'b1;
                                state         <= ST_BREAK;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (rxFilt) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // End-of-packet fires once per burst: a good byte arms it, the pulse disarms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            gapCnt          <= '0;
            byteSeen        <= 1'b0;
            RxD_endofpacket <= 1'b0;
        end else begin
            RxD_endofpacket <= 1'b0;
            if (RxD_data_ready) begin
                byteSeen <= 1'b1;
            end
            if (state != ST_IDLE) begin
                gapCnt <= '0;
            end else if (tick) begin
                if (!rxFilt) begin
                    gapCnt <= '0;
                end else if (gapCnt != GapMax) begin
                    gapCnt <= gapCnt + 1'b1;
                    if (gapCnt == GapLast && byteSeen) begin
                        RxD_endofpacket <= 1'b1;
                        byteSeen        <= 1'b0;
                    end
                end
            end
        end
    end

    assign RxD_idle = (gapCnt == GapMax);
    assign RxD_busy = (state != ST_IDLE);
    assign dbgState = state;

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- 8N1 asynchronous serial receiver. It is the receive-side counterpart of the existing UART transmitter on the host serial link.
- Samples RxD at Oversampling× baud, qualifies the start bit, samples each bit at mid-bit and presents the byte with a one-cycle strobe.
- Also reports framing errors, line idle and end-of-packet to the command decoder.

Parameters:
- ClkFrequency, `UART_CLK, system clock frequency in Hz.
- Baud, `UART_BAUD, line rate in bit/s.
- Oversampling, 16, samples per bit (power of two, 8 or 16).
- AccWidth, 16, width of the fractional tick accumulator.
- GapBits, 10, idle bit-times that declare end of packet.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- RxD  input  1  asynchronous serial line; idle high.
- RxD_data  output  8  last good byte, LSB first on line.
- RxD_data_ready  output  1  one-cycle pulse when RxD_data has just been updated.
- RxD_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- RxD_idle  output  1  high while the line has been high for at least GapBits bit-times.
- RxD_endofpacket  output  1  one-cycle pulse on the rising edge of RxD_idle, only if a byte was received since the last pulse.
- RxD_busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset:
  - clk and synchronous active-high rst, as already decided.
  - rst forces: synchronizer stages to 1; FSM to IDLE; accumulator, sample counter, bit counter and gap counter to 0.
  - Reset values: RxD_data=0x00, RxD_data_ready=0, RxD_frame_err=0, RxD_endofpacket=0, RxD_busy=0, RxD_idle=0.
  - Reset mid-byte discards the partial byte and produces no strobe.
- Tick generation:
  - (AccWidth+1)-bit accumulator, Inc = ((Baud*Oversampling << (AccWidth-4)) + (ClkFrequency>>5)) / (ClkFrequency>>4).
  - Each clk: acc <= acc[AccWidth-1:0] + Inc. Tick = acc[AccWidth]. The accumulator is free-running.
- Input conditioning:
  - 2-FF synchronizer.
  - 3-tap majority filter, updated on each tick, producing rx_f.
- FSM, advancing only on ticks:
  - IDLE: when rx_f=0, go to START with sample counter=0.
  - START: count Oversampling/2 ticks. If rx_f is still 0, go to DATA with counters cleared. If rx_f=1, it is a false start; return to IDLE with no strobe.
  - DATA: every Oversampling ticks, sample rx_f into the shift register (LSB first). After 8 bits, go to STOP.
  - STOP: after Oversampling ticks, sample rx_f.
    - rx_f=1: on the next clk, RxD_data <= shift register, RxD_data_ready=1 for one clk, then go to IDLE.
    - rx_f=0: RxD_frame_err=1 for one clk, RxD_data is unchanged; go to BREAK.
  - BREAK: wait until rx_f=1, then go to IDLE.
- Latency: the strobe is asserted no later than 3 clk after the mid-stop-bit tick.
- Back-to-back frames: a frame with exactly one stop bit followed immediately by a start bit must be received. IDLE may detect the new start on the tick immediately after the stop sample.
- Gap counter:
  - Counts ticks while FSM=IDLE and rx_f=1, saturating at GapBits*Oversampling.
  - Cleared by any low sample or by leaving IDLE.
  - RxD_idle = counter saturated.
  - RxD_endofpacket pulses for one clk when saturation is first reached and the "byte seen" flag is set. The pulse clears the flag; a good byte sets it.
- Simultaneous events: data_ready and endofpacket can never coincide, since data_ready leaves the gap counter at 0. Frame errors do not set the "byte seen" flag.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - Function computing the accumulator Inc from ClkFrequency, Baud, Oversampling and AccWidth, so TX and RX share it.
- Sub-module uart_baud_tick_gen: accumulator plus tick output, with an Oversampling parameter. A later cleanup of the transmitter can reuse it with Oversampling=1.

Test Plan:
- Setup: ClkFrequency=40e6, Baud=115200 (≈347 clk/bit); send 0x55 with 1 stop bit -> exactly one data_ready pulse, RxD_data=0x55, no frame_err.
- Send 0xA3 then 0x3C back-to-back with 1 stop bit each, plus 0x00 and 0xFF -> four data_ready pulses in order with the correct values.
- Low glitch of 60 clk on an idle line -> no strobe, FSM back to IDLE, busy deasserted within 1 bit-time.
- Send 0xA3 with stop bit forced to 0, then line held low 3 bit-times -> one frame_err pulse, RxD_data keeps its prior value, no data_ready. The next valid 0x12 after the line returns high is received.
- Send 0x41, then hold the line high -> idle and a single endofpacket pulse ≈10×347 clk after the stop bit. A second idle period with no new byte gives no pulse.
- Assert rst for 1 clk during bit 4 of a byte -> no strobe, all outputs at reset values. The following byte 0x7E is received correctly.
- Baud tolerance: ±2 % baud skew on 0xC9 -> received correctly.
